// File: rtl/arbiter_pkg.sv
// Shared sizing for the input-buffered arbiter: port count, word width, FIFO depth, almost-full level.
// Also holds the port-index type and the modulo-NPORTS wrap helper.
package arbiter_pkg;

  localparam int NPORTS    = 8;
  localparam int WIDTH     = 8;
  localparam int LOG_DEPTH = 4;
  localparam int AF_LEVEL  = 12;
  localparam int PORT_W    = $clog2(NPORTS);

  typedef logic [PORT_W-1:0] port_idx_t;

  function automatic port_idx_t port_wrap(input int unsigned p);
    return port_idx_t'(p % NPORTS);
  endfunction

endpackage

// File: rtl/rr_fifo_arbiter_if.sv
// Producer-side push/data/backpressure plus the stallable output stream of the arbiter.
// The master modport drives push/d/stall; the slave modport is the arbiter itself.
interface rr_fifo_arbiter_if;
  import arbiter_pkg::*;

  logic [0:NPORTS-1]       push;
  logic [NPORTS*WIDTH-1:0] d;
  logic [0:NPORTS-1]       full;
  logic [0:NPORTS-1]       almost_full;
  logic [WIDTH-1:0]        q;
  logic                    stall;
  logic                    valid;

  modport master (
    output push, d, stall,
    input  full, almost_full, q, valid
  );

  modport slave (
    input  push, d, stall,
    output full, almost_full, q, valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push into a full FIFO is dropped, pop of an empty FIFO is ignored.
// full/almost_full are registered from next-state occupancy; q shows the head word combinationally.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 4,
  parameter int AF_LEVEL  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  typedef logic [LOG_DEPTH-1:0] ptr_t;
  typedef logic [LOG_DEPTH:0]   cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  cnt_t             count;
  cnt_t             count_nxt;
  logic             do_push;
  logic             do_pop;

  // Acceptance uses the registered full, so a pop in the same cycle cannot free room for a push.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign empty     = (count == '0);
  assign count_nxt = count + cnt_t'(do_push) - cnt_t'(do_pop);
  assign q         = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      count       <= count_nxt;
      full        <= (count_nxt == cnt_t'(DEPTH));
      almost_full <= (count_nxt >= cnt_t'(AF_LEVEL));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= d;
  end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Per-port FIFOs drained one word per cycle into a registered q/valid; push-to-valid is 2 cycles, stall freezes q/valid/pointer.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN for fixed priority with port 0 highest.
module rr_fifo_arbiter
  import arbiter_pkg::*;
(
  input logic              clk,
  input logic              rst,
  rr_fifo_arbiter_if.slave bus
);

  logic [NPORTS-1:0] empty;
  logic [NPORTS-1:0] pop;
  logic [0:NPORTS-1] full_v;
  logic [0:NPORTS-1] af_v;
  logic [WIDTH-1:0]  fifo_q [NPORTS];
  logic              gnt_vld;
  port_idx_t         gnt_idx;
  logic [WIDTH-1:0]  q_r;
  logic              valid_r;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    sync_fifo #(
      .WIDTH    (WIDTH),
      .LOG_DEPTH(LOG_DEPTH),
      .AF_LEVEL (AF_LEVEL)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (bus.push[i]),
      .pop        (pop[i]),
      .d          (bus.d[NPORTS*WIDTH-1-i*WIDTH -: WIDTH]),
      .q          (fifo_q[i]),
      .empty      (empty[i]),
      .full       (full_v[i]),
      .almost_full(af_v[i])
    );

    assign pop[i] = !bus.stall && gnt_vld && (gnt_idx == port_idx_t'(i));
  end

  assign bus.full        = full_v;
  assign bus.almost_full = af_v;

`ifdef ARB_FIXED_PRIORITY_EN
  // Scan downward so the lowest non-empty index is the last one written.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (!empty[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = port_idx_t'(k);
      end
    end
  end
`else
  port_idx_t rr_ptr;
  port_idx_t scan_idx;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NPORTS; k++) begin
      scan_idx = port_wrap(32'(rr_ptr) + k);
      if (!gnt_vld && !empty[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (!bus.stall && gnt_vld) begin
      rr_ptr <= port_wrap(32'(gnt_idx) + 1);
    end
  end
`endif

  // q keeps its last word when nothing is granted; only valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r     <= '0;
      valid_r <= 1'b0;
    end else if (!bus.stall) begin
      valid_r <= gnt_vld;
      if (gnt_vld) q_r <= fifo_q[gnt_idx];
    end
  end

  assign bus.q     = q_r;
  assign bus.valid = valid_r;

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model of the arbiter.
module tb_rr_fifo_arbiter;
  import arbiter_pkg::*;

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_fifo_arbiter_if bus();

  rr_fifo_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: one queue per port, a pointer and the expected output register.
  logic [WIDTH-1:0]  mq [NPORTS][$];
  logic              m_valid;
  logic [WIDTH-1:0]  m_q;
  int                m_ptr;
  logic [0:NPORTS-1] m_full;
  logic [0:NPORTS-1] m_af;

`ifdef ARB_FIXED_PRIORITY_EN
  logic [7:0] exp_rr [6] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1};
`else
  logic [7:0] exp_rr [6] = '{8'hA0, 8'hB0, 8'hC0, 8'hA1, 8'hB1, 8'hC1};
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_d(input int port, input logic [7:0] v);
    bus.d[NPORTS*WIDTH-1-port*WIDTH -: WIDTH] = v;
  endtask

  always @(posedge clk) begin
    int sz [NPORTS];
    int g;
    for (int i = 0; i < NPORTS; i++) sz[i] = mq[i].size();
    if (rst) begin
      for (int i = 0; i < NPORTS; i++) mq[i].delete();
      m_valid = 1'b0;
      m_q     = '0;
      m_ptr   = 0;
    end else begin
      if (!bus.stall) begin
        g = -1;
        for (int k = 0; k < NPORTS; k++) begin
          int p;
          p = (m_ptr + k) % NPORTS;
          if (g < 0 && sz[p] > 0) g = p;
        end
        if (g >= 0) begin
          m_q     = mq[g].pop_front();
          m_valid = 1'b1;
`ifndef ARB_FIXED_PRIORITY_EN
          m_ptr   = (g + 1) % NPORTS;
`endif
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < NPORTS; i++)
        if (bus.push[i] && sz[i] < DEPTH)
          mq[i].push_back(bus.d[NPORTS*WIDTH-1-i*WIDTH -: WIDTH]);
    end
    for (int i = 0; i < NPORTS; i++) begin
      m_full[i] = (mq[i].size() == DEPTH);
      m_af[i]   = (mq[i].size() >= AF_LEVEL);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", bus.valid, m_valid);
      chk("model_q", bus.q, m_q);
      chk("model_full", bus.full, m_full);
      chk("model_almost_full", bus.almost_full, m_af);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t, required finish before 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pp [3] = '{70, 35, 10};
    int sp [3] = '{60, 20, 5};

    rst       = 1'b1;
    bus.push  = '0;
    bus.d     = '0;
    bus.stall = 1'b0;

    // Reset state
    repeat (10) @(negedge clk);
    chk("reset_valid", bus.valid, 0);
    chk("reset_q", bus.q, 0);
    chk("reset_full", bus.full, 0);
    chk("reset_almost_full", bus.almost_full, 0);
    chk_en = 1'b1;
    rst    = 1'b0;

    // Single-port burst: first valid two edges after the first push
    for (int k = 0; k < 8; k++) begin
      bus.push[0] = 1'b1;
      set_d(0, k[7:0]);
      @(negedge clk);
      chk("burst_valid", bus.valid, k >= 1);
      if (k >= 1) chk("burst_q", bus.q, k - 1);
    end
    bus.push = '0;
    @(negedge clk);
    chk("burst_last_valid", bus.valid, 1);
    chk("burst_last_q", bus.q, 7);
    @(negedge clk);
    chk("burst_idle_valid", bus.valid, 0);

    // Round-robin across ports 0, 3, 7 from a reset pointer
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.stall = 1'b1;
    for (int w = 0; w < 2; w++) begin
      bus.push[0] = 1'b1;
      bus.push[3] = 1'b1;
      bus.push[7] = 1'b1;
      set_d(0, 8'hA0 + 8'(w));
      set_d(3, 8'hB0 + 8'(w));
      set_d(7, 8'hC0 + 8'(w));
      @(negedge clk);
    end
    bus.push  = '0;
    bus.stall = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("rr_valid", bus.valid, 1);
      chk("rr_q", bus.q, exp_rr[j]);
    end
    @(negedge clk);
    chk("rr_drained_valid", bus.valid, 0);

    // Overflow of port 2 while stalled
    bus.stall = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus.push[2] = 1'b1;
      set_d(2, 8'(k - 1));
      @(negedge clk);
      chk("ovf_almost_full", bus.almost_full[2], k >= AF_LEVEL);
      chk("ovf_full", bus.full[2], k >= DEPTH);
    end
    bus.push  = '0;
    bus.stall = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("ovf_out_valid", bus.valid, 1);
      chk("ovf_out_q", bus.q, j);
    end
    @(negedge clk);
    chk("ovf_drained_valid", bus.valid, 0);

    // Stall holding q=0x55
    bus.push[1] = 1'b1;
    set_d(1, 8'h55);
    @(negedge clk);
    set_d(1, 8'h66);
    @(negedge clk);
    chk("stall_pre_q", bus.q, 8'h55);
    bus.push  = '0;
    bus.stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold_valid", bus.valid, 1);
      chk("stall_hold_q", bus.q, 8'h55);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    chk("stall_next_valid", bus.valid, 1);
    chk("stall_next_q", bus.q, 8'h66);
    @(negedge clk);
    chk("stall_idle_valid", bus.valid, 0);

    // Mid-stream reset with three loaded ports and a word in flight
    bus.stall = 1'b1;
    for (int w = 0; w < 2; w++) begin
      bus.push[1] = 1'b1;
      bus.push[4] = 1'b1;
      bus.push[6] = 1'b1;
      set_d(1, 8'h11 + 8'(w));
      set_d(4, 8'h44 + 8'(w));
      set_d(6, 8'h66 + 8'(w));
      @(negedge clk);
    end
    bus.push  = '0;
    bus.stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mreset_valid", bus.valid, 0);
    chk("mreset_q", bus.q, 0);
    chk("mreset_full", bus.full, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mreset_empty_valid", bus.valid, 0);
    end

    // Randomized traffic in three load regimes
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 600; c++) begin
        for (int i = 0; i < NPORTS; i++) begin
          bus.push[i] = ($urandom_range(99) < pp[ph]);
          set_d(i, 8'($urandom));
        end
        bus.stall = ($urandom_range(99) < sp[ph]);
        rst       = ($urandom_range(499) == 0);
        @(negedge clk);
      end
    end
    rst       = 1'b0;
    bus.push  = '0;
    bus.stall = 1'b0;
    repeat (140) @(negedge clk);
    chk("final_drained_valid", bus.valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
